// File: rtl/isb_prefetch_sched_if.sv
// Interface bundle for isb_prefetch_sched: prefetch candidates, demand access
// handshake and the shared memory request/response port.
//   master : isb + demand requester + memory model (drives inputs of the scheduler)
//   slave  : the scheduler itself
interface isb_prefetch_sched_if #(
  parameter int unsigned AW   = 16,
  parameter int unsigned CNTW = 8
);
  logic            pf_v;
  logic [AW-1:0]   pf_addr;
  logic            dem_v;
  logic [AW-1:0]   dem_addr;
  logic            dem_ready;
  logic            dem_done;
  logic            dem_hit;
  logic            mem_req_v;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_pf;
  logic            mem_req_ready;
  logic            mem_resp_v;
  logic [CNTW-1:0] pf_drop_cnt;

  modport master (
    output pf_v, pf_addr, dem_v, dem_addr, mem_req_ready, mem_resp_v,
    input  dem_ready, dem_done, dem_hit, mem_req_v, mem_req_addr, mem_req_pf, pf_drop_cnt
  );

  modport slave (
    input  pf_v, pf_addr, dem_v, dem_addr, mem_req_ready, mem_resp_v,
    output dem_ready, dem_done, dem_hit, mem_req_v, mem_req_addr, mem_req_pf, pf_drop_cnt
  );
endinterface

// File: rtl/isb_prefetch_sched.sv
// Prefetch/demand scheduler for the ISB. Prefetch candidates are parked in a
// small stream buffer and issued to memory only when no demand is waiting;
// demands that hit a prefetched line complete from the buffer. One memory
// request is outstanding at a time.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of isb_prefetch_sched_if (pf_*, dem_*, mem_*, pf_drop_cnt)
module isb_prefetch_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned CNTW  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  isb_prefetch_sched_if.slave bus
);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DEM_REQ, S_DEM_WAIT, S_PF_REQ, S_PF_WAIT} state_t;
  typedef enum logic [1:0] {ST_PEND, ST_ISSUED, ST_READY} slot_st_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    dem_addr_q, dem_addr_d;
  logic [IW-1:0]    pf_idx_q, pf_idx_d;
  logic [DEPTH-1:0] slot_vld_q, slot_vld_d;
  slot_st_t         slot_st_q [DEPTH];
  slot_st_t         slot_st_d [DEPTH];
  logic [AW-1:0]    slot_addr_q [DEPTH];
  logic [AW-1:0]    slot_addr_d [DEPTH];
  logic [CNTW-1:0]  drop_cnt_q, drop_cnt_d;

  logic            mem_req_v_q, mem_req_v_d;
  logic            mem_req_pf_q, mem_req_pf_d;
  logic [AW-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic            dem_done_q, dem_done_d;
  logic            dem_hit_q, dem_hit_d;

  logic            dem_acc_c, hit_c, dup_c;
  logic            m_found, p_found, f_found, r_found;
  logic [IW-1:0]   m_idx, p_idx, f_idx, r_idx;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dem_addr_q     <= '0;
      pf_idx_q       <= '0;
      slot_vld_q     <= '0;
      drop_cnt_q     <= '0;
      mem_req_v_q    <= 1'b0;
      mem_req_pf_q   <= 1'b0;
      mem_req_addr_q <= '0;
      dem_done_q     <= 1'b0;
      dem_hit_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_st_q[IW'(i)]   <= ST_PEND;
        slot_addr_q[IW'(i)] <= '0;
      end
    end else begin
      state_q        <= state_d;
      dem_addr_q     <= dem_addr_d;
      pf_idx_q       <= pf_idx_d;
      slot_vld_q     <= slot_vld_d;
      drop_cnt_q     <= drop_cnt_d;
      mem_req_v_q    <= mem_req_v_d;
      mem_req_pf_q   <= mem_req_pf_d;
      mem_req_addr_q <= mem_req_addr_d;
      dem_done_q     <= dem_done_d;
      dem_hit_q      <= dem_hit_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_st_q[IW'(i)]   <= slot_st_d[IW'(i)];
        slot_addr_q[IW'(i)] <= slot_addr_d[IW'(i)];
      end
    end
  end

  // Next state, slot buffer updates and candidate insertion
  always_comb begin
    state_d     = state_q;
    dem_addr_d  = dem_addr_q;
    pf_idx_d    = pf_idx_q;
    slot_vld_d  = slot_vld_q;
    slot_st_d   = slot_st_q;
    slot_addr_d = slot_addr_q;
    drop_cnt_d  = drop_cnt_q;
    hit_c       = 1'b0;
    dup_c       = 1'b0;
    m_found = 1'b0; m_idx = '0;
    p_found = 1'b0; p_idx = '0;
    f_found = 1'b0; f_idx = '0;
    r_found = 1'b0; r_idx = '0;
    dem_acc_c = bus.dem_v && (state_q == S_IDLE);

    // Lookups all use slot state at the start of the cycle
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_vld_q[IW'(i)] && (slot_addr_q[IW'(i)] == bus.dem_addr) && !m_found) begin
        m_found = 1'b1; m_idx = IW'(i);
      end
      if (slot_vld_q[IW'(i)] && (slot_st_q[IW'(i)] == ST_PEND) && !p_found) begin
        p_found = 1'b1; p_idx = IW'(i);
      end
      if (!slot_vld_q[IW'(i)] && !f_found) begin
        f_found = 1'b1; f_idx = IW'(i);
      end
      if (slot_vld_q[IW'(i)] && (slot_addr_q[IW'(i)] == bus.pf_addr)) dup_c = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dem_acc_c) begin
          if (m_found && (slot_st_q[m_idx] == ST_READY)) begin
            slot_vld_d[m_idx] = 1'b0;
            hit_c             = 1'b1;
          end else begin
            // A pending candidate for the same line is promoted to the demand
            if (m_found && (slot_st_q[m_idx] == ST_PEND)) slot_vld_d[m_idx] = 1'b0;
            dem_addr_d = bus.dem_addr;
            state_d    = S_DEM_REQ;
          end
        end else if (p_found) begin
          pf_idx_d = p_idx;
          state_d  = S_PF_REQ;
        end
      end
      S_DEM_REQ:  if (bus.mem_req_ready) state_d = S_DEM_WAIT;
      S_DEM_WAIT: if (bus.mem_resp_v)    state_d = S_IDLE;
      S_PF_REQ: begin
        if (bus.mem_req_ready) begin
          slot_st_d[pf_idx_q] = ST_ISSUED;
          state_d             = S_PF_WAIT;
        end
      end
      S_PF_WAIT: begin
        if (bus.mem_resp_v) begin
          slot_st_d[pf_idx_q] = ST_READY;
          state_d             = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Replacement victim: lowest READY slot, excluding one being freed by a hit
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_vld_q[IW'(i)] && (slot_st_q[IW'(i)] == ST_READY) &&
          !(hit_c && (m_idx == IW'(i))) && !r_found) begin
        r_found = 1'b1; r_idx = IW'(i);
      end
    end

    if (bus.pf_v) begin
      if (((state_q == S_DEM_REQ) || (state_q == S_DEM_WAIT)) && (bus.pf_addr == dem_addr_q))
        dup_c = 1'b1;
      if (dem_acc_c && (bus.pf_addr == bus.dem_addr)) dup_c = 1'b1;
      if (!dup_c) begin
        if (f_found) begin
          slot_vld_d[f_idx]  = 1'b1;
          slot_st_d[f_idx]   = ST_PEND;
          slot_addr_d[f_idx] = bus.pf_addr;
        end else if (r_found) begin
          slot_st_d[r_idx]   = ST_PEND;
          slot_addr_d[r_idx] = bus.pf_addr;
        end else if (drop_cnt_q != {CNTW{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNTW'(1);
        end
      end
    end
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    mem_req_v_d    = (state_d == S_DEM_REQ) || (state_d == S_PF_REQ);
    mem_req_pf_d   = (state_d == S_PF_REQ);
    mem_req_addr_d = '0;
    if (state_d == S_DEM_REQ)     mem_req_addr_d = dem_addr_d;
    else if (state_d == S_PF_REQ) mem_req_addr_d = slot_addr_q[pf_idx_d];
    dem_done_d = hit_c || ((state_q == S_DEM_WAIT) && bus.mem_resp_v);
    dem_hit_d  = hit_c;
  end

  assign bus.dem_ready    = (state_q == S_IDLE);
  assign bus.dem_done     = dem_done_q;
  assign bus.dem_hit      = dem_hit_q;
  assign bus.mem_req_v    = mem_req_v_q;
  assign bus.mem_req_pf   = mem_req_pf_q;
  assign bus.mem_req_addr = mem_req_addr_q;
  assign bus.pf_drop_cnt  = drop_cnt_q;
endmodule
